// File: rtl/core_pkg.sv
// Shared core types: program-counter FSM states and next-PC mux selects.
package core_pkg;

   typedef enum logic [1:0] {
      PC_BOOT,
      PC_RUN,
      PC_HALT
   } pc_state_t;

   typedef enum logic [1:0] {
      SEL_TRAP,
      SEL_REDIR,
      SEL_HOLD,
      SEL_SEQ
   } pc_sel_t;

endpackage : core_pkg

// File: rtl/program_counter_add.sv
// Sequential-step incrementer; wraps modulo 2^DWIDTH with no carry out.
module program_counter_add #(
   parameter int DWIDTH = 32,
   parameter int INCR   = 4
) (
   input  logic [DWIDTH-1:0] i_pc,
   output logic [DWIDTH-1:0] o_pc_next
);

   assign o_pc_next = i_pc + DWIDTH'(INCR);

endmodule : program_counter_add

// File: rtl/program_counter_unit.sv
// Registered program counter: BOOT/RUN/HALT FSM, priority next-PC mux
// (trap > redirect > hold > sequential), misaligned-redirect capture and instret.
module program_counter_unit
   import core_pkg::*;
#(
   parameter int              DWIDTH       = 32,
   parameter int              INCR         = 4,
   parameter logic [DWIDTH-1:0] RESET_VECTOR = '0,
   parameter int              CWIDTH       = 64
) (
   input  logic              Clk,
   input  logic              Reset_N,
   input  logic              Stall,
   input  logic              Redirect_Valid,
   input  logic [DWIDTH-1:0] Redirect_Target,
   input  logic              Trap_Valid,
   input  logic [DWIDTH-1:0] Trap_Vector,
   input  logic              Halt_Req,
   input  logic              Resume_Req,
   output logic [DWIDTH-1:0] Program_Count_Curr,
   output logic [DWIDTH-1:0] Program_Count_Next,
   output logic              Pc_Valid,
   output logic              Halted,
   output logic              Misalign_Exc,
   output logic [DWIDTH-1:0] Misalign_Addr,
   output logic [CWIDTH-1:0] Instret_Count
);

   localparam int ALIGN_BITS = $clog2(INCR);
   localparam logic [DWIDTH-1:0] ALIGN_MASK = DWIDTH'((1 << ALIGN_BITS) - 1);

   pc_state_t         r_state;
   pc_state_t         w_state_nxt;
   pc_sel_t           w_sel;
   logic [DWIDTH-1:0] r_pc;
   logic [DWIDTH-1:0] w_pc_nxt;
   logic [DWIDTH-1:0] w_pc_seq;
   logic [DWIDTH-1:0] w_trap_aligned;
   logic              w_redir_misaligned;
   logic              w_misalign;
   logic              w_retire;
   logic              r_misalign_exc;
   logic [DWIDTH-1:0] r_misalign_addr;
   logic [CWIDTH-1:0] r_instret;

   program_counter_add #(
      .DWIDTH (DWIDTH),
      .INCR   (INCR)
   ) u_add (
      .i_pc      (r_pc),
      .o_pc_next (w_pc_seq)
   );

   assign w_trap_aligned     = Trap_Vector & ~ALIGN_MASK;
   assign w_redir_misaligned = |(Redirect_Target & ALIGN_MASK);

   // Halt_Req takes precedence over any pending redirect in RUN, so a
   // redirect arriving with a halt is neither taken nor flagged.
   always_comb begin
      w_state_nxt = r_state;
      w_sel       = SEL_HOLD;
      w_misalign  = 1'b0;
      w_retire    = 1'b0;
      case (r_state)
         PC_BOOT: begin
            w_state_nxt = PC_RUN;
         end
         PC_RUN: begin
            if (Trap_Valid) begin
               w_sel = SEL_TRAP;
            end else if (Halt_Req) begin
               w_state_nxt = PC_HALT;
            end else if (Redirect_Valid) begin
               if (w_redir_misaligned) begin
                  w_misalign = 1'b1;
               end else begin
                  w_sel = SEL_REDIR;
               end
            end else if (!Stall) begin
               w_sel = SEL_SEQ;
            end
            w_retire = !Stall && !Trap_Valid && !w_misalign;
         end
         PC_HALT: begin
            if (Trap_Valid) begin
               w_sel       = SEL_TRAP;
               w_state_nxt = PC_RUN;
            end else if (Resume_Req) begin
               w_state_nxt = PC_RUN;
            end
         end
         default: begin
            w_state_nxt = PC_BOOT;
         end
      endcase
   end

   always_comb begin
      w_pc_nxt = r_pc;
      case (w_sel)
         SEL_TRAP:  w_pc_nxt = w_trap_aligned;
         SEL_REDIR: w_pc_nxt = Redirect_Target;
         SEL_SEQ:   w_pc_nxt = w_pc_seq;
         default:   w_pc_nxt = r_pc;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_N) begin
      if (!Reset_N) begin
         r_state         <= PC_BOOT;
         r_pc            <= RESET_VECTOR;
         r_misalign_exc  <= 1'b0;
         r_misalign_addr <= '0;
         r_instret       <= '0;
      end else begin
         r_state        <= w_state_nxt;
         r_pc           <= w_pc_nxt;
         r_misalign_exc <= w_misalign;
         if (w_misalign) begin
            r_misalign_addr <= Redirect_Target;
         end
         if (w_retire) begin
            r_instret <= r_instret + CWIDTH'(1);
         end
      end
   end

   assign Program_Count_Curr = r_pc;
   assign Program_Count_Next = w_pc_seq;
   assign Pc_Valid           = (r_state == PC_RUN);
   assign Halted             = (r_state == PC_HALT);
   assign Misalign_Exc       = r_misalign_exc;
   assign Misalign_Addr      = r_misalign_addr;
   assign Instret_Count      = r_instret;

endmodule : program_counter_unit

// File: tb/tb_program_counter_unit.sv
// Directed bench for program_counter_unit with hand-computed expected values.
module tb_program_counter_unit;

   logic        Clk;
   logic        Reset_N;
   logic        Stall;
   logic        Redirect_Valid;
   logic [31:0] Redirect_Target;
   logic        Trap_Valid;
   logic [31:0] Trap_Vector;
   logic        Halt_Req;
   logic        Resume_Req;
   logic [31:0] Program_Count_Curr;
   logic [31:0] Program_Count_Next;
   logic        Pc_Valid;
   logic        Halted;
   logic        Misalign_Exc;
   logic [31:0] Misalign_Addr;
   logic [63:0] Instret_Count;

   int n_checks = 0;
   int n_errors = 0;

   program_counter_unit #(
      .DWIDTH       (32),
      .INCR         (4),
      .RESET_VECTOR (32'h0000_0000),
      .CWIDTH       (64)
   ) dut (
      .Clk                (Clk),
      .Reset_N            (Reset_N),
      .Stall              (Stall),
      .Redirect_Valid     (Redirect_Valid),
      .Redirect_Target    (Redirect_Target),
      .Trap_Valid         (Trap_Valid),
      .Trap_Vector        (Trap_Vector),
      .Halt_Req           (Halt_Req),
      .Resume_Req         (Resume_Req),
      .Program_Count_Curr (Program_Count_Curr),
      .Program_Count_Next (Program_Count_Next),
      .Pc_Valid           (Pc_Valid),
      .Halted             (Halted),
      .Misalign_Exc       (Misalign_Exc),
      .Misalign_Addr      (Misalign_Addr),
      .Instret_Count      (Instret_Count)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk_pc(input string tag, input logic [31:0] pc, input logic v,
                         input logic h, input logic [63:0] ir);
      chk({tag, "_pc"},      {32'h0, Program_Count_Curr}, {32'h0, pc});
      chk({tag, "_valid"},   {63'h0, Pc_Valid},           {63'h0, v});
      chk({tag, "_halted"},  {63'h0, Halted},             {63'h0, h});
      chk({tag, "_instret"}, Instret_Count,               ir);
   endtask

   initial begin
      Reset_N         = 1'b0;
      Stall           = 1'b0;
      Redirect_Valid  = 1'b0;
      Redirect_Target = '0;
      Trap_Valid      = 1'b0;
      Trap_Vector     = '0;
      Halt_Req        = 1'b0;
      Resume_Req      = 1'b0;

      #12;
      chk_pc("reset", 32'h0, 1'b0, 1'b0, 64'd0);
      chk("reset_exc",  {63'h0, Misalign_Exc}, 64'd0);
      chk("reset_addr", {32'h0, Misalign_Addr}, 64'd0);
      Reset_N = 1'b1;
      #1;
      chk_pc("boot", 32'h0, 1'b0, 1'b0, 64'd0);

      // BOOT -> RUN, then sequential fetch
      step(); chk_pc("run0", 32'h0, 1'b1, 1'b0, 64'd0);
      chk("link0", {32'h0, Program_Count_Next}, 64'h4);
      step(); chk_pc("run4", 32'h4, 1'b1, 1'b0, 64'd1);
      step(); chk_pc("run8", 32'h8, 1'b1, 1'b0, 64'd2);
      step(); chk_pc("run12", 32'hC, 1'b1, 1'b0, 64'd3);

      // aligned redirect
      Redirect_Valid = 1'b1; Redirect_Target = 32'h100;
      step(); chk_pc("redir100", 32'h100, 1'b1, 1'b0, 64'd4);

      // redirect beats stall; stalled cycle does not retire
      Redirect_Target = 32'h2000; Stall = 1'b1;
      step(); chk_pc("redir_stall", 32'h2000, 1'b1, 1'b0, 64'd4);

      Stall = 1'b0; Redirect_Target = 32'h100;
      step(); chk_pc("back100", 32'h100, 1'b1, 1'b0, 64'd5);

      // misaligned redirect rejected
      Redirect_Target = 32'h2002;
      step(); chk_pc("misal", 32'h100, 1'b1, 1'b0, 64'd5);
      chk("misal_exc",  {63'h0, Misalign_Exc}, 64'd1);
      chk("misal_addr", {32'h0, Misalign_Addr}, 64'h2002);
      Redirect_Valid = 1'b0;
      step(); chk_pc("misal_after", 32'h104, 1'b1, 1'b0, 64'd6);
      chk("misal_exc_clr", {63'h0, Misalign_Exc}, 64'd0);
      chk("misal_addr_hold", {32'h0, Misalign_Addr}, 64'h2002);

      // trap beats redirect and halt
      Trap_Valid = 1'b1; Trap_Vector = 32'h8000_0003;
      Redirect_Valid = 1'b1; Redirect_Target = 32'h3000; Halt_Req = 1'b1;
      step(); chk_pc("trap", 32'h8000_0000, 1'b1, 1'b0, 64'd6);
      Trap_Valid = 1'b0; Redirect_Valid = 1'b0; Halt_Req = 1'b0;
      step(); chk_pc("trap_seq", 32'h8000_0004, 1'b1, 1'b0, 64'd7);

      // halt at 0x40 (stalled entry so the halt edge retires nothing)
      Redirect_Valid = 1'b1; Redirect_Target = 32'h40;
      step(); chk_pc("to40", 32'h40, 1'b1, 1'b0, 64'd8);
      Redirect_Valid = 1'b0; Halt_Req = 1'b1; Stall = 1'b1;
      step(); chk_pc("halt_in", 32'h40, 1'b0, 1'b1, 64'd8);
      Stall = 1'b0; Redirect_Valid = 1'b1; Redirect_Target = 32'h5000;
      step(); chk_pc("halt_hold", 32'h40, 1'b0, 1'b1, 64'd8);
      Redirect_Valid = 1'b0; Resume_Req = 1'b1;
      step(); chk_pc("resume", 32'h40, 1'b1, 1'b0, 64'd8);
      Resume_Req = 1'b0; Halt_Req = 1'b0;
      step(); chk_pc("resume_seq", 32'h44, 1'b1, 1'b0, 64'd9);

      // wrap-around
      Redirect_Valid = 1'b1; Redirect_Target = 32'hFFFF_FFFC;
      step(); chk_pc("top", 32'hFFFF_FFFC, 1'b1, 1'b0, 64'd10);
      chk("link_wrap", {32'h0, Program_Count_Next}, 64'h0);
      Redirect_Valid = 1'b0;
      step(); chk_pc("wrap", 32'h0, 1'b1, 1'b0, 64'd11);

      // async reset mid-stall
      Redirect_Valid = 1'b1; Redirect_Target = 32'h600;
      step(); chk_pc("to600", 32'h600, 1'b1, 1'b0, 64'd12);
      Redirect_Valid = 1'b0; Stall = 1'b1;
      step(); chk_pc("stall600", 32'h600, 1'b1, 1'b0, 64'd12);
      #2 Reset_N = 1'b0;
      #1;
      chk_pc("async_rst", 32'h0, 1'b0, 1'b0, 64'd0);
      chk("async_rst_addr", {32'h0, Misalign_Addr}, 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_program_counter_unit
